// File: rtl/byte_data_memory.sv
// Byte-addressable big-endian data memory with a serial preload port and a registered CPU load port.
// Optional macro DMEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses and pulses `misaligned`.
module byte_data_memory #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        store,
  input  logic              load_last,
  output logic              ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              misaligned
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [7:0]       r_mem [DEPTH_BYTES];

  logic [IDX_W-1:0] w_idx   [4];
  logic [7:0]       w_rbyte [4];
  logic [7:0]       w_wbyte [4];
  logic [3:0]       w_lane;
  logic [31:0]      w_rdata;
  logic             w_run;
  logic             w_misalign;
  logic             w_do_rd;
  logic             w_do_wr;
  logic             w_sext;
  logic             w_unused;

  assign w_unused = ^address[ADDR_W-1:IDX_W];
  assign w_run    = (r_state == S_RUN);
  assign ready    = w_run;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((size == 2'b01) && address[0]) ||
                      (size[1] && (address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_do_rd = w_run && mem_read  && !w_misalign;
  assign w_do_wr = w_run && mem_write && !w_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_LOAD && load && load_last) w_state_nxt = S_RUN;
  end

  // Lane k is the byte at address+k; lane 0 is the most significant byte of the access.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k]   = address[IDX_W-1:0] + IDX_W'(k);
      w_rbyte[k] = r_mem[w_idx[k]];
      w_wbyte[k] = write_data[31-8*k -: 8];
    end
    w_sext = !load_unsigned;
    case (size)
      2'b00: begin
        w_lane     = 4'b0001;
        w_wbyte[0] = write_data[7:0];
        w_rdata    = {{24{w_sext & w_rbyte[0][7]}}, w_rbyte[0]};
      end
      2'b01: begin
        w_lane     = 4'b0011;
        w_wbyte[0] = write_data[15:8];
        w_wbyte[1] = write_data[7:0];
        w_rdata    = {{16{w_sext & w_rbyte[0][7]}}, w_rbyte[0], w_rbyte[1]};
      end
      default: begin
        w_lane  = 4'b1111;
        w_rdata = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (r_state == S_LOAD && load) r_cnt <= r_cnt + IDX_W'(1);
  end

  // Array is deliberately not reset so preloaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_LOAD && load) begin
        r_mem[r_cnt] <= store;
      end else if (w_do_wr) begin
        for (int k = 0; k < 4; k++)
          if (w_lane[k]) r_mem[w_idx[k]] <= w_wbyte[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      read_valid <= w_do_rd;
      misaligned <= w_run && (mem_read || mem_write) && w_misalign;
      if (w_do_rd) read_data <= w_rdata;
    end
  end
endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: byte-array reference model plus literal pins from the test plan.
// Honours DMEM_MISALIGN_TRAP_EN when compiled with it.
module tb_byte_data_memory;
  localparam int DEPTH = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load, load_last, mem_read, mem_write, load_unsigned;
  logic [7:0]  store;
  logic [1:0]  size;
  logic [31:0] address, write_data;
  logic        ready, read_valid, misaligned;
  logic [31:0] read_data;

  byte_data_memory #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .load_last(load_last),
    .ready(ready), .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [DEPTH];
  bit          m_run;
  int          m_cnt;
  logic [31:0] exp_rd;
  bit          exp_rv, exp_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ready", 32'(ready), 32'(m_run));
    chk("read_valid", 32'(read_valid), 32'(exp_rv));
    chk("misaligned", 32'(misaligned), 32'(exp_mis));
    chk("read_data", read_data, exp_rd);
  endtask

  // Advance the model by one clock with the inputs currently applied, then compare.
  task automatic step();
    int n, a;
    logic [31:0] v;
    bit mis;
    exp_rv = 0;
    exp_mis = 0;
    if (!m_run) begin
      if (load) begin
        m_mem[m_cnt] = store;
        m_cnt = (m_cnt + 1) % DEPTH;
        if (load_last) m_run = 1;
      end
    end else begin
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      a = int'(address % DEPTH);
      mis = TRAP && ((n == 2 && address % 2 != 0) || (n == 4 && address % 4 != 0));
      if (mem_read && !mis) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(m_mem[(a + i) % DEPTH]);
        if (!load_unsigned && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!load_unsigned && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        exp_rd = v;
        exp_rv = 1;
      end
      if (mem_write && !mis)
        for (int i = 0; i < n; i++) m_mem[(a + i) % DEPTH] = 8'(write_data >> (8 * (n - 1 - i)));
      exp_mis = mis && (mem_read || mem_write);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    load = 0; load_last = 0; store = 0; mem_read = 0; mem_write = 0;
    size = 0; load_unsigned = 0; address = 0; write_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #2;
    m_run = 0; m_cnt = 0; exp_rd = 0; exp_rv = 0; exp_mis = 0;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
  endtask

  task automatic ld(input logic [7:0] b, input bit en, input bit last);
    idle_inputs();
    load = en; store = b; load_last = last;
    mem_read = 1; mem_write = 1; size = 2'b10; write_data = 32'hFFFF_FFFF;
    step();
  endtask

  task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit lu,
                    input logic [31:0] addr, input logic [31:0] wd);
    idle_inputs();
    mem_read = rd; mem_write = wr; size = sz; load_unsigned = lu;
    address = addr; write_data = wd;
    load = 1; store = 8'hEE; load_last = 1;
    step();
  endtask

  task automatic pin(input string name, input logic [31:0] req);
    chk({name, "_dut"}, read_data, req);
    chk({name, "_model"}, exp_rd, req);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_run = 0; m_cnt = 0; exp_rd = 0; exp_rv = 0; exp_mis = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    @(posedge clk); #1;
    check_outputs();
    rst = 0;

    // Preload, with a stray load_last and ignored CPU requests mixed in.
    ld(8'h11, 1, 0);
    ld(8'h99, 0, 1);
    ld(8'h22, 1, 0);
    ld(8'h33, 1, 0);
    ld(8'h44, 1, 1);
    chk("ready_after_last", 32'(ready), 32'd1);
    op(1, 0, 2'b10, 0, 32'h0, 0);
    pin("lw0", 32'h1122_3344);
    chk("lw0_valid", 32'(read_valid), 32'd1);
    op(0, 0, 2'b00, 0, 32'h0, 0);
    chk("valid_drop", 32'(read_valid), 32'd0);

    for (int i = 1; i < 4; i++) op(0, 1, 2'b10, 0, 32'(4 * i), $urandom);

    op(0, 1, 2'b10, 0, 32'h8, 32'h80FF_7F01);
    op(1, 0, 2'b00, 0, 32'h8, 0);  pin("lb8", 32'hFFFF_FF80);
    op(1, 0, 2'b00, 1, 32'h8, 0);  pin("lbu8", 32'h0000_0080);
    op(1, 0, 2'b01, 0, 32'hA, 0);  pin("lh10", 32'h0000_7F01);
    op(1, 0, 2'b01, 1, 32'h8, 0);  pin("lhu8", 32'h0000_80FF);
    op(1, 0, 2'b01, 0, 32'h8, 0);  pin("lh8", 32'hFFFF_80FF);

    op(0, 1, 2'b10, 0, 32'h4, 32'hA);
    op(1, 1, 2'b10, 0, 32'h4, 32'hB); pin("rbw_old", 32'hA);
    op(1, 0, 2'b11, 0, 32'h4, 0);     pin("rbw_new", 32'hB);

    op(0, 1, 2'b10, 0, 32'h1C, 32'hDEAD_BEEF);
    op(1, 0, 2'b10, 0, 32'hFFFF_F00C, 0); pin("wrap", 32'hDEAD_BEEF);

`ifdef DMEM_MISALIGN_TRAP_EN
    op(0, 1, 2'b10, 0, 32'h5, 32'h1234_5678);
    chk("mis_sw", 32'(misaligned), 32'd1);
    op(1, 0, 2'b10, 0, 32'h4, 0); pin("mis_unchanged", 32'hB);
    op(1, 0, 2'b01, 0, 32'h3, 0);
    chk("mis_lh", 32'(misaligned), 32'd1);
    chk("mis_lh_novalid", 32'(read_valid), 32'd0);
`else
    op(0, 1, 2'b10, 0, 32'hE, 32'h1234_5678);
    chk("unal_nomis", 32'(misaligned), 32'd0);
    op(1, 0, 2'b00, 1, 32'hE, 0); pin("unal14", 32'h12);
    op(1, 0, 2'b00, 1, 32'hF, 0); pin("unal15", 32'h34);
    op(1, 0, 2'b00, 1, 32'h0, 0); pin("unal0", 32'h56);
    op(1, 0, 2'b00, 1, 32'h1, 0); pin("unal1", 32'h78);
`endif

    for (int i = 0; i < 400; i++)
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);

    // Reset in the middle of a preload restarts the counter but keeps bytes.
    do_reset();
    ld(8'hA1, 1, 0);
    ld(8'hA2, 1, 0);
    ld(8'hA3, 1, 0);
    do_reset();
    ld(8'h55, 1, 1);
    chk("reload_ready", 32'(ready), 32'd1);
    op(1, 0, 2'b00, 1, 32'h0, 0); pin("reload0", 32'h55);
    op(1, 0, 2'b00, 1, 32'h1, 0); pin("reload1", 32'hA2);
    op(1, 0, 2'b00, 1, 32'h2, 0); pin("reload2", 32'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Parametrised, byte-addressable data memory for the MIPS datapath, succeeding the single-byte-lane memory. Preloaded after reset by a serial byte loader, then serves CPU loads and stores of byte, halfword and word size with sign/zero extension and a registered read port. Sits between the ALU address output and the write-back mux. The `ready` output gates the rest of the pipeline until preload completes.

## Interface
- `DEPTH_BYTES`, 1024: memory size in bytes; power of two, at least 4.
- `ADDR_W`, 32: CPU address width; only the low log2(`DEPTH_BYTES`) bits index memory.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: loader byte valid.
- `store` in 8: loader byte.
- `load_last` in 1: qualifies `load`; marks the final preload byte.
- `ready` out 1: high once preload is complete (RUN state).
- `mem_read` in 1: CPU load request.
- `mem_write` in 1: CPU store request.
- `size` in 2: access size; 00 byte, 01 halfword, 10 word, 11 treated as word.
- `load_unsigned` in 1: zero-extend byte/halfword loads (lbu/lhu).
- `address` in `ADDR_W`: CPU byte address.
- `write_data` in 32: store data; the low `size` bytes are used.
- `read_data` out 32: registered load result.
- `read_valid` out 1: one-cycle pulse when `read_data` is updated.
- `misaligned` out 1: one-cycle pulse flagging a rejected access (only with the macro; otherwise tied 0).

## Operation
- FSM has two states, LOAD and RUN. Reset enters LOAD.
- Reset values: counter 0, `ready` 0, `read_data` 0, `read_valid` 0, `misaligned` 0. Memory array is not cleared.
- **LOAD state**
  - Each clock with `load`=1 writes `store` to mem[counter] and increments counter. Counter wraps modulo `DEPTH_BYTES`.
  - `load` with `load_last`=1 writes its byte, then moves to RUN. `ready`=1 from the next cycle.
  - `mem_read` and `mem_write` are ignored in LOAD. `load_last` without `load` is ignored.
- **RUN state**
  - `load`, `store` and `load_last` are ignored. RUN is left only by `rst`.
- Byte order is big-endian (MIPS): a word at A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}. A halfword at A is {mem[A], mem[A+1]}.
- Byte indices wrap modulo `DEPTH_BYTES`. Upper address bits are ignored.
- Store: `mem_write` in RUN writes `write_data[7:0]` (byte), `[15:0]` (half) or `[31:0]` (word) at the clock edge, using the byte order above.
- Load: `mem_read` in RUN captures the addressed data, extended to 32 bits (sign-extended unless `load_unsigned`=1). It drives `read_data` with `read_valid`=1 after the edge.
- `read_data` holds its last value when no load completes.
- Simultaneous `mem_read` and `mem_write`: both are performed, and the read returns pre-write data (read-before-write).
- Reset mid-LOAD: counter returns to 0 and preload restarts at byte 0. Bytes already written persist.

## Timing
- Preload: one byte per cycle. `ready` rises one cycle after the `load_last` edge.
- Store latency: 1 cycle. The data is visible to a read issued in the next cycle.
- Load latency: 1 cycle, request at edge N, `read_data`/`read_valid` valid after edge N.
- Back-to-back reads every cycle are supported. `read_valid` deasserts in any cycle without a completed read.
- `rst` acts immediately, without waiting for `clk`: outputs go to their reset values and `ready` drops within the reset assertion.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Rejected accesses: a halfword with `address[0]`=1, or a word (`size` 10 or 11) with `address[1:0]`≠0.
  - A rejected store writes nothing. A rejected load leaves `read_data` unchanged and gives no `read_valid`.
  - `misaligned` pulses high for 1 cycle after the edge.
- Not defined: unaligned accesses are performed byte-wise on consecutive (wrapping) indices, and `misaligned` is constant 0.

## Test plan
- Preload: reset, stream bytes 0x11,0x22,0x33,0x44 with `load_last` on 0x44 -> `ready`=0 throughout, `ready`=1 the next cycle; lw @0 -> `read_data`=0x11223344, `read_valid` pulse.
- Byte and halfword extension: after sw 0x80FF7F01 @8, the following loads return:
  - lb @8 -> 0xFFFFFF80; lbu @8 -> 0x00000080.
  - lh @10 -> 0x00007F01.
  - lhu @8 -> 0x000080FF; lh @8 -> 0xFFFF80FF.
- Read-before-write: lw @4 returns 0xA; same cycle sw 0xB @4 -> `read_data`=0xA; next lw @4 -> 0xB.
- Wrap: with `DEPTH_BYTES`=16, sw 0xDEADBEEF @0x1C -> lw @0xC returns 0xDEADBEEF. Without the macro, sw @0xE writes mem[14],[15],[0],[1].
- Misaligned (macro defined): sw 0x12345678 @5 -> `misaligned` pulse, memory unchanged. lh @3 -> `misaligned` pulse, no `read_valid`.
- Reset mid-load: load 3 bytes, assert `rst`, reload 0x55 with `load_last` -> mem[0]=0x55, mem[1..2] keep the earlier bytes, `ready`=1.
